// File: rtl/tdm_pkg.sv
// Shared TDM definitions: FSM states, slot-counter sizing and the channel
// defaults that the mux-side framer also uses.
package tdm_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  localparam int unsigned TDM_DEF_CHANNELS = 4;
  localparam int unsigned TDM_DEF_WIDTH    = 2;

  // Bits needed to hold slot indices 0..ch-1 (at least one bit).
  function automatic int unsigned tdm_slot_w(input int unsigned ch);
    return (ch <= 2) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter with clear, load-to-1 and advance controls.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_DEF_CHANNELS,
  parameter int unsigned SW       = tdm_slot_w(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          en,
  output logic [SW-1:0] count,
  output logic          last
);

  logic [SW-1:0] r_count;

  // Slot register: clear beats load, load beats advance; wraps at CHANNELS-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (load1) begin
      r_count <= SW'(1);
    end else if (en) begin
      if (r_count == SW'(CHANNELS - 1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign last  = (r_count == SW'(CHANNELS - 1));

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: tracks frame alignment from the SOF marker and
// steers each sample into its channel holding register with a valid strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_DEF_CHANNELS,
  parameter int unsigned WIDTH    = TDM_DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sof,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int unsigned SW = tdm_slot_w(CHANNELS);

  tdm_state_e r_state, w_state_nxt;

  logic [SW-1:0]       w_slot;
  logic                w_last;
  logic                w_cnt_clr;
  logic                w_cnt_load1;
  logic                w_cnt_en;
  logic                w_wr_en;
  logic                w_wr_zero;
  logic                w_err;
  logic [CHANNELS-1:0] w_wr;

  logic [CHANNELS*WIDTH-1:0] r_ch_data;
  logic [CHANNELS-1:0]       r_ch_valid;
  logic                      r_frame_done;
  logic                      r_locked;
  logic                      r_sync_err;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .load1 (w_cnt_load1),
    .en    (w_cnt_en),
    .count (w_slot),
    .last  (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, slot-counter control and write-target selection per beat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_load1 = 1'b0;
    w_cnt_en    = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_zero   = 1'b0;
    w_err       = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          if (in_sof) begin
            w_wr_en     = 1'b1;
            w_wr_zero   = 1'b1;
            w_cnt_load1 = 1'b1;
            w_state_nxt = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (in_sof) begin
            // Expected SOF and early SOF both realign onto channel 0.
            w_err       = (w_slot != '0);
            w_wr_en     = 1'b1;
            w_wr_zero   = 1'b1;
            w_cnt_load1 = 1'b1;
          end else if (w_slot != '0) begin
            w_wr_en  = 1'b1;
            w_cnt_en = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // One-hot channel write enable from the current slot (or channel 0 on SOF).
  always_comb begin
    w_wr = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_wr_zero) begin
        w_wr[k] = w_wr_en && (k == 0);
      end else begin
        w_wr[k] = w_wr_en && (w_slot == SW'(k));
      end
    end
  end

  // Output registers: channel holding data plus single-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (w_wr[k]) begin
          r_ch_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
      r_ch_valid   <= w_wr;
      r_frame_done <= w_cnt_en && w_last;
      r_locked     <= (w_state_nxt == ST_LOCK);
      r_sync_err   <= w_err;
    end
  end

  assign ch_data    = r_ch_data;
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign locked     = r_locked;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a 4-channel and a 3-channel instance share one input
// stream; each is compared every cycle against its own frame-level model.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_sof;

  logic [7:0] w4_ch_data;
  logic [3:0] w4_ch_valid;
  logic       w4_frame_done, w4_locked, w4_sync_err;
  logic [5:0] w3_ch_data;
  logic [2:0] w3_ch_valid;
  logic       w3_frame_done, w3_locked, w3_sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(4), .WIDTH(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .ch_data(w4_ch_data), .ch_valid(w4_ch_valid), .frame_done(w4_frame_done),
    .locked(w4_locked), .sync_err(w4_sync_err)
  );

  tdm_demux #(.CHANNELS(3), .WIDTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .ch_data(w3_ch_data), .ch_valid(w3_ch_valid), .frame_done(w3_frame_done),
    .locked(w3_locked), .sync_err(w3_sync_err)
  );

  // Reference model, index 0 = 4 channels, index 1 = 3 channels.
  int         nch [2] = '{4, 3};
  bit         m_locked [2];
  int         m_slot [2];
  logic [1:0] m_data [2][4];
  int         m_valid [2];
  bit         m_fd [2];
  bit         m_err [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] packed_exp(input int d);
    logic [31:0] p = '0;
    for (int k = 0; k < nch[d]; k++) p[k*2 +: 2] = m_data[d][k];
    return p;
  endfunction

  task automatic model_write(input int d, input int k, input logic [1:0] dat);
    m_data[d][k] = dat;
    m_valid[d]   = 1 << k;
    m_fd[d]      = (k == nch[d] - 1);
  endtask

  task automatic model_step(input int d, input bit r, input bit v, input bit s,
                            input logic [1:0] dat);
    m_valid[d] = 0;
    m_fd[d]    = 1'b0;
    m_err[d]   = 1'b0;
    if (r) begin
      m_locked[d] = 1'b0;
      m_slot[d]   = 0;
      for (int k = 0; k < 4; k++) m_data[d][k] = 2'b00;
    end else if (v) begin
      if (!m_locked[d]) begin
        if (s) begin
          model_write(d, 0, dat);
          m_slot[d]   = 1;
          m_locked[d] = 1'b1;
        end
      end else if (s) begin
        m_err[d] = (m_slot[d] != 0);
        model_write(d, 0, dat);
        m_slot[d] = 1;
      end else if (m_slot[d] != 0) begin
        model_write(d, m_slot[d], dat);
        m_slot[d] = (m_slot[d] + 1) % nch[d];
      end else begin
        m_err[d]    = 1'b1;
        m_locked[d] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ch4_data",  32'(w4_ch_data),    packed_exp(0));
    check_eq("ch4_valid", 32'(w4_ch_valid),   32'(m_valid[0]));
    check_eq("ch4_fdone", 32'(w4_frame_done), 32'(m_fd[0]));
    check_eq("ch4_lock",  32'(w4_locked),     32'(m_locked[0]));
    check_eq("ch4_serr",  32'(w4_sync_err),   32'(m_err[0]));
    check_eq("ch3_data",  32'(w3_ch_data),    packed_exp(1));
    check_eq("ch3_valid", 32'(w3_ch_valid),   32'(m_valid[1]));
    check_eq("ch3_fdone", 32'(w3_frame_done), 32'(m_fd[1]));
    check_eq("ch3_lock",  32'(w3_locked),     32'(m_locked[1]));
    check_eq("ch3_serr",  32'(w3_sync_err),   32'(m_err[1]));
  endtask

  // Drive one cycle, step both models on the edge, sample 1 time unit later.
  task automatic beat(input bit v, input bit s, input logic [1:0] dat, input bit r = 1'b0);
    rst      = r;
    in_valid = v;
    in_sof   = s;
    in_data  = dat;
    @(posedge clk);
    model_step(0, r, v, s, dat);
    model_step(1, r, v, s, dat);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 2'($urandom));
  endtask

  // One full frame of n channels using the 3,1,2,0 pattern, with gap idles between beats.
  task automatic frame(input int n, input int gap);
    logic [1:0] pat [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    for (int k = 0; k < n; k++) begin
      beat(1'b1, k == 0, pat[k]);
      if (k != n - 1) idle(gap);
    end
  endtask

  initial begin
    // Reset with random input activity.
    for (int i = 0; i < 3; i++) beat(1'($urandom), 1'($urandom), 2'($urandom), 1'b1);
    check_eq("rst_lock", 32'(w4_locked), 32'd0);
    check_eq("rst_data", 32'(w4_ch_data), 32'd0);
    // Beats without SOF in HUNT are dropped.
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 2'($urandom));
    check_eq("hunt_lock", 32'(w4_locked), 32'd0);

    for (int t = 0; t < 2; t++) begin
      int n = (t == 0) ? 4 : 3;
      beat(1'b0, 1'b0, 2'd0, 1'b1);
      // Clean back-to-back frames, twice.
      frame(n, 0);
      frame(n, 0);
      if (n == 4) check_eq("clean_data", 32'(w4_ch_data), 32'h27);
      // Gapped frame.
      frame(n, 2);
      // Early SOF at slot 2, then the next beat goes to channel 1.
      beat(1'b1, 1'b1, 2'd1);
      beat(1'b1, 1'b0, 2'd2);
      beat(1'b1, 1'b1, 2'd3);
      if (n == 4) begin
        check_eq("early_serr",  32'(w4_sync_err), 32'd1);
        check_eq("early_valid", 32'(w4_ch_valid), 32'd1);
        check_eq("early_ch0",   32'(w4_ch_data[1:0]), 32'd3);
      end
      beat(1'b1, 1'b0, 2'd0);
      if (n == 4) check_eq("early_next", 32'(w4_ch_valid), 32'd2);
      for (int k = 2; k < n; k++) beat(1'b1, 1'b0, 2'($urandom));
      // Full frame, then a missing SOF, then relock.
      frame(n, 0);
      beat(1'b1, 1'b0, 2'd2);
      if (n == 4) begin
        check_eq("miss_serr",  32'(w4_sync_err), 32'd1);
        check_eq("miss_valid", 32'(w4_ch_valid), 32'd0);
        check_eq("miss_lock",  32'(w4_locked),   32'd0);
      end
      frame(n, 1);
      // Reset after slot 1 is written, then a normal frame.
      beat(1'b1, 1'b1, 2'd1);
      beat(1'b1, 1'b0, 2'd2);
      beat(1'b1, 1'b1, 2'd3, 1'b1);
      if (n == 4) check_eq("midrst_data", 32'(w4_ch_data), 32'd0);
      frame(n, 0);
    end

    // Randomized traffic, mostly well-formed frames with occasional faults.
    for (int t = 0; t < 2; t++) begin
      int n   = (t == 0) ? 4 : 3;
      int pos = 0;
      for (int i = 0; i < 1500; i++) begin
        bit v = ($urandom_range(0, 9) < 7);
        bit s = (pos == 0);
        bit r = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 19) == 0) s = ~s;
        beat(v, s, 2'($urandom), r);
        if (v) pos = s ? 1 : (pos + 1) % n;
        if (r) pos = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
